// File: rtl/lif_neuron_update_pkg.sv
// Shared definitions for the LIF neuron update slice: FP32 field widths,
// default neuron constants and the sequencing FSM encoding.
package lif_pkg;
    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned FP_W   = SIGN_W + EXP_W + MANT_W;

    localparam logic [31:0] FP_DECAY   = 32'h3F733333;  // 0.95
    localparam logic [31:0] FP_GAIN    = 32'h3DCCCCCD;  // 0.1
    localparam logic [31:0] FP_V_REST  = 32'hC2820000;  // -65.0
    localparam logic [31:0] FP_V_TH    = 32'hC25C0000;  // -55.0
    localparam logic [31:0] FP_V_RESET = 32'hC28C0000;  // -70.0

    typedef enum logic [2:0] {
        IDLE,
        MUL_V,
        MUL_I,
        ADD,
        CMP_WB,
        OUT
    } lif_state_t;
endpackage

// File: rtl/Addition_Subtraction.sv
// FP32 adder/subtractor (i_add_bar_sub=1 subtracts), 3 guard bits, round-to-nearest-even.
module Addition_Subtraction import lif_pkg::*; (
    input  logic [31:0] i_a_operand,
    input  logic [31:0] i_b_operand,
    input  logic        i_add_bar_sub,
    output logic        o_exception,
    output logic [31:0] o_result
);
    logic [31:0] w_b, w_big, w_small;
    logic [7:0]  w_e_big, w_e_small, w_diff;
    logic [26:0] w_m_big, w_m_small, w_m_shift, w_norm;
    logic [27:0] w_sum;
    logic [8:0]  w_exp;
    logic [4:0]  w_lz;
    logic [24:0] w_mant_rnd;
    logic        w_flush, w_round;

    always_comb begin
        w_b         = {i_b_operand[31] ^ i_add_bar_sub, i_b_operand[30:0]};
        o_exception = (&i_a_operand[30:23]) | (&i_b_operand[30:23]);
        if (i_a_operand[30:0] >= w_b[30:0]) begin
            w_big = i_a_operand; w_small = w_b;
        end else begin
            w_big = w_b;         w_small = i_a_operand;
        end
        w_e_big   = (w_big[30:23] == '0)   ? 8'd1 : w_big[30:23];
        w_e_small = (w_small[30:23] == '0) ? 8'd1 : w_small[30:23];
        w_m_big   = {|w_big[30:23],   w_big[22:0],   3'b000};
        w_m_small = {|w_small[30:23], w_small[22:0], 3'b000};
        w_diff    = w_e_big - w_e_small;
        // alignment keeps every shifted-out bit as a sticky bit
        if (w_diff >= 8'd27) begin
            w_m_shift = {26'd0, |w_m_small};
        end else begin
            w_m_shift    = w_m_small >> w_diff;
            w_m_shift[0] = w_m_shift[0] | (|(w_m_small & ~('1 << w_diff)));
        end
        if (w_big[31] ^ w_small[31])
            w_sum = {1'b0, w_m_big} - {1'b0, w_m_shift};
        else
            w_sum = {1'b0, w_m_big} + {1'b0, w_m_shift};
        w_exp   = {1'b0, w_e_big};
        w_lz    = '0;
        w_flush = (w_sum == '0);
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = w_exp + 9'd1;
        end else begin
            for (int unsigned i = 0; i < 27; i++)
                if (w_sum[i]) w_lz = 5'(26 - i);
            w_norm  = w_sum[26:0] << w_lz;
            w_flush = w_flush || (w_exp <= {4'd0, w_lz});
            w_exp   = w_exp - {4'd0, w_lz};
        end
        w_round    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_round};
        w_exp      = w_exp + {8'd0, w_mant_rnd[24]};
        if (o_exception)
            o_result = {w_big[31], 8'hFF, 23'd0};
        else if (w_flush)
            o_result = '0;
        else if (w_exp >= 9'd255)
            o_result = {w_big[31], 8'hFF, 23'd0};
        else
            o_result = {w_big[31], w_exp[7:0], w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0]};
    end
endmodule

// File: rtl/Multiplication.sv
// FP32 multiplier, round-to-nearest-even; denormal inputs are treated as zero.
module Multiplication import lif_pkg::*; (
    input  logic [31:0] i_a_operand,
    input  logic [31:0] i_b_operand,
    output logic        o_exception,
    output logic        o_overflow,
    output logic        o_underflow,
    output logic [31:0] o_result
);
    logic        w_sign, w_zero, w_norm, w_round;
    logic [47:0] w_prod;
    logic [22:0] w_mant;
    logic [24:0] w_mant_rnd;
    logic [9:0]  w_exp;

    always_comb begin
        w_sign      = i_a_operand[31] ^ i_b_operand[31];
        o_exception = (&i_a_operand[30:23]) | (&i_b_operand[30:23]);
        w_zero      = (i_a_operand[30:23] == '0) | (i_b_operand[30:23] == '0);
        w_prod      = {24'd0, 1'b1, i_a_operand[22:0]} * {24'd0, 1'b1, i_b_operand[22:0]};
        w_norm      = w_prod[47];
        if (w_norm) begin
            w_mant  = w_prod[46:24];
            w_round = w_prod[23] & ((|w_prod[22:0]) | w_prod[24]);
        end else begin
            w_mant  = w_prod[45:23];
            w_round = w_prod[22] & ((|w_prod[21:0]) | w_prod[23]);
        end
        w_mant_rnd = {2'b01, w_mant} + {24'd0, w_round};
        // bit 9 set means the biased exponent went negative
        w_exp = {2'b00, i_a_operand[30:23]} + {2'b00, i_b_operand[30:23]}
              + {9'd0, w_norm} + {9'd0, w_mant_rnd[24]} - 10'd127;
        o_overflow  = !o_exception && !w_zero && !w_exp[9] && (w_exp[8:0] >= 9'd255);
        o_underflow = !o_exception && !w_zero && (w_exp[9] || (w_exp == '0));
        if (o_exception)
            o_result = {w_sign, 8'hFF, 23'd0};
        else if (w_zero || o_underflow)
            o_result = {w_sign, 31'd0};
        else if (o_overflow)
            o_result = {w_sign, 8'hFF, 23'd0};
        else
            o_result = {w_sign, w_exp[7:0], w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0]};
    end
endmodule

// File: rtl/fp_compare_ge.sv
// Combinational FP32 a >= b using sign-magnitude ordering; +0 and -0 compare equal.
module fp_compare_ge import lif_pkg::*; (
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic            o_ge
);
    logic [EXP_W+MANT_W-1:0] w_mag_a;
    logic [EXP_W+MANT_W-1:0] w_mag_b;

    always_comb begin
        w_mag_a = i_a[EXP_W+MANT_W-1:0];
        w_mag_b = i_b[EXP_W+MANT_W-1:0];
        if ((w_mag_a == '0) && (w_mag_b == '0))
            o_ge = 1'b1;
        else if (i_a[FP_W-1] != i_b[FP_W-1])
            o_ge = !i_a[FP_W-1];
        else if (!i_a[FP_W-1])
            o_ge = (w_mag_a >= w_mag_b);
        else
            o_ge = (w_mag_a <= w_mag_b);
    end
endmodule

// File: rtl/lif_neuron_update.sv
// Leaky-integrate-and-fire update v' = DECAY*v + GAIN*I over a bank of neurons,
// sequenced through one shared multiplier and one adder; spikes reset the potential.
module lif_neuron_update import lif_pkg::*; #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned ID_W        = 4,
    parameter logic [31:0] DECAY       = FP_DECAY,
    parameter logic [31:0] GAIN        = FP_GAIN,
    parameter logic [31:0] V_REST      = FP_V_REST,
    parameter logic [31:0] V_TH        = FP_V_TH,
    parameter logic [31:0] V_RESET     = FP_V_RESET
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [31:0]     in_current,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [31:0]     out_v,
    output logic            out_spike,
    output logic            out_err
);
    lif_state_t      r_state, w_state_nxt;
    logic [31:0]     r_v [NUM_NEURONS];
    logic [ID_W-1:0] r_id, r_out_id;
    logic [31:0]     r_cur, r_vin, r_p1, r_p2, r_s, r_out_v;
    logic            r_err, r_out_spike, r_out_err;
    logic [31:0]     w_mul_a, w_mul_b, w_mul_res, w_add_res, w_wb_v;
    logic            w_mul_exc, w_mul_ovf, w_mul_unf, w_add_exc, w_ge, w_spike;

    Multiplication u_mul (
        .i_a_operand (w_mul_a),
        .i_b_operand (w_mul_b),
        .o_exception (w_mul_exc),
        .o_overflow  (w_mul_ovf),
        .o_underflow (w_mul_unf),
        .o_result    (w_mul_res)
    );

    Addition_Subtraction u_add (
        .i_a_operand   (r_p1),
        .i_b_operand   (r_p2),
        .i_add_bar_sub (1'b0),
        .o_exception   (w_add_exc),
        .o_result      (w_add_res)
    );

    fp_compare_ge u_cmp (
        .i_a  (r_s),
        .i_b  (V_TH),
        .o_ge (w_ge)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = MUL_V;
            MUL_V:   w_state_nxt = MUL_I;
            MUL_I:   w_state_nxt = ADD;
            ADD:     w_state_nxt = CMP_WB;
            CMP_WB:  w_state_nxt = OUT;
            OUT:     if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == OUT);
        w_mul_a   = DECAY;
        w_mul_b   = r_vin;
        if (r_state == MUL_I) begin
            w_mul_a = GAIN;
            w_mul_b = r_cur;
        end
        // an FPU exception suppresses the spike but still parks the neuron at V_RESET
        w_spike = w_ge && !r_err;
        w_wb_v  = (r_err || w_ge) ? V_RESET : r_s;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) r_v[i] <= V_REST;
            r_id        <= '0;
            r_cur       <= '0;
            r_vin       <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_s         <= '0;
            r_err       <= 1'b0;
            r_out_id    <= '0;
            r_out_v     <= '0;
            r_out_spike <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_id  <= in_id;
                    r_cur <= in_current;
                    r_vin <= r_v[in_id];
                end
                MUL_V: begin
                    r_p1  <= w_mul_res;
                    r_err <= w_mul_exc | w_mul_ovf | w_mul_unf;
                end
                MUL_I: begin
                    r_p2  <= w_mul_res;
                    r_err <= r_err | w_mul_exc | w_mul_ovf | w_mul_unf;
                end
                ADD: begin
                    r_s   <= w_add_res;
                    r_err <= r_err | w_add_exc;
                end
                CMP_WB: begin
                    r_v[r_id]   <= w_wb_v;
                    r_out_id    <= r_id;
                    r_out_v     <= w_wb_v;
                    r_out_spike <= w_spike;
                    r_out_err   <= r_err;
                end
                default: ;
            endcase
        end
    end

    assign out_id    = r_out_id;
    assign out_v     = r_out_v;
    assign out_spike = r_out_spike;
    assign out_err   = r_out_err;
endmodule

// File: tb/tb_lif_neuron_update.sv
// Scoreboard bench for lif_neuron_update: directed updates with hand-computed potentials.
module tb_lif_neuron_update;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] v;
        logic        spike;
        logic        err;
    } exp_t;

    localparam logic [31:0] FIVE = 32'h40A00000;
    localparam logic [31:0] HUND = 32'h42C80000;
    localparam logic [31:0] ZERO = 32'h00000000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_id = '0;
    logic [31:0] in_current = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_id;
    logic [31:0] out_v;
    logic        out_spike;
    logic        out_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    lif_neuron_update #(.NUM_NEURONS(16), .ID_W(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_id      (in_id),
        .in_current (in_current),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_v      (out_v),
        .out_spike  (out_spike),
        .out_err    (out_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got id %0d v %h with nothing expected", out_id, out_v);
                end else begin
                    e = sb.pop_front();
                    check("out_id",    64'(out_id),    64'(e.id));
                    check("out_v",     64'(out_v),     64'(e.v));
                    check("out_spike", 64'(out_spike), 64'(e.spike));
                    check("out_err",   64'(out_err),   64'(e.err));
                end
            end
        end
    endtask

    // Called at posedge+#1 while the DUT is idle; returns at posedge+#1 back in IDLE.
    task automatic send(input logic [3:0] id, input logic [31:0] cur, input logic [31:0] ev,
                        input logic es, input logic ee, input logic hold);
        int unsigned n;
        logic [38:0] snap;
        out_ready  = !hold;
        in_valid   = 1'b1;
        in_id      = id;
        in_current = cur;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge CLK); #1; n++; end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        sb.push_back('{id: id, v: ev, spike: es, err: ee});
        n = 0;
        while (!out_valid && n < 20) begin @(posedge CLK); #1; n++; end
        check("latency", 64'(n), 64'd4);
        if (hold) begin
            snap       = {out_valid, out_id, out_v, out_spike, out_err};
            in_valid   = 1'b1;
            in_id      = id ^ 4'd1;
            in_current = HUND;
            for (int unsigned k = 0; k < 6; k++) begin
                @(posedge CLK); #1;
                check("hold_stable", 64'({out_valid, out_id, out_v, out_spike, out_err}), 64'(snap));
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        n = 0;
        while (out_valid && n < 20) begin @(posedge CLK); #1; n++; end
        check("handshake_cycles", 64'(n), 64'd1);
        check("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("FAIL timeout: simulation exceeded time limit");
                $fatal(1, "timeout");
            end
        join_none

        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_id",    64'(out_id),    64'd0);
        check("rst_out_v",     64'(out_v),     64'd0);
        check("rst_out_spike", 64'(out_spike), 64'd0);
        check("rst_out_err",   64'(out_err),   64'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        send(4'd0, FIVE, 32'hC2750000, 1'b0, 1'b0, 1'b0);  // -61.25
        send(4'd3, HUND, 32'hC28C0000, 1'b1, 1'b0, 1'b0);  // -51.75 fires
        send(4'd3, ZERO, 32'hC2850000, 1'b0, 1'b0, 1'b0);  // -66.5
        send(4'd5, FIVE, 32'hC2750000, 1'b0, 1'b0, 1'b1);  // back-pressure hold
        repeat (3) begin
            @(posedge CLK); #1;
            check("no_extra_output", 64'(out_valid), 64'd0);
        end
        send(4'd7, FIVE, 32'hC2750000, 1'b0, 1'b0, 1'b0);
        send(4'd7, FIVE, 32'hC266C000, 1'b0, 1'b0, 1'b0);  // -57.6875 from written-back value

        // Abort an update of id 0 while it sits in ADD
        in_valid   = 1'b1;
        in_id      = 4'd0;
        in_current = FIVE;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_id",    64'(out_id),    64'd0);
        check("abort_out_v",     64'(out_v),     64'd0);
        check("abort_out_spike", 64'(out_spike), 64'd0);
        check("abort_out_err",   64'(out_err),   64'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        send(4'd0, ZERO, 32'hC2770000, 1'b0, 1'b0, 1'b0);  // -61.75 from V_REST

        send(4'd1, 32'h7F7FFFFF, 32'hC28C0000, 1'b1, 1'b0, 1'b0);
        send(4'd2, 32'h7F800000, 32'hC28C0000, 1'b0, 1'b1, 1'b0);

        repeat (5) @(posedge CLK);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lif_neuron_update.md
Name: lif_neuron_update

Overview:
- Sequencing stage directly downstream of the single-precision FP adder/subtractor and multiplier.
- Performs the leaky-integrate-and-fire membrane update for a bank of neurons: v' = DECAY*v + GAIN*I.
- Compares v' against the firing threshold, emits a spike, and writes back either v' or the reset potential.
- Instantiates one Multiplication and one Addition_Subtraction (add mode) and reuses them across the FSM steps.

Parameters:
- NUM_NEURONS, 16, number of neuron potentials held internally (power of two).
- ID_W, 4, neuron index width (log2 NUM_NEURONS).
- DECAY, 32'h3F733333, leak factor (0.95).
- GAIN, 32'h3DCCCCCD, input-current scale (0.1).
- V_REST, 32'hC2820000, potential loaded at reset (-65.0).
- V_TH, 32'hC25C0000, firing threshold (-55.0).
- V_RESET, 32'hC28C0000, post-spike potential (-70.0).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- in_valid  in  1  update request valid.
- in_ready  out  1  block can accept a request.
- in_id  in  ID_W  neuron index.
- in_current  in  32  IEEE-754 input current I.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_id  out  ID_W  neuron index of result.
- out_v  out  32  potential written back.
- out_spike  out  1  neuron fired.
- out_err  out  1  an FPU exception occurred during this update.

Behaviour:
- Reset (RESET low, async):
  - All NUM_NEURONS potentials = V_REST; FSM = IDLE.
  - in_ready=1, out_valid=0, out_id=0, out_v=0, out_spike=0, out_err=0.
  - Internal temporaries cleared.
- Reset mid-operation aborts the update. No writeback occurs; the potential array returns to V_REST.
- FSM states: IDLE, MUL_V, MUL_I, ADD, CMP_WB, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_id and in_current, read v[in_id], go to MUL_V.
- MUL_V: multiplier operands (DECAY, v); register product P1 and mul exception; go to MUL_I.
- MUL_I: operands (GAIN, I); register P2, OR in exception; go to ADD.
- ADD: adder operands (P1, P2), add mode; register S, OR in exception; go to CMP_WB.
- CMP_WB:
  - spike = (S >= V_TH) via fp_compare_ge.
  - If err: spike forced 0 and v[id] <= V_RESET.
  - Else if spike: v[id] <= V_RESET.
  - Else: v[id] <= S.
  - Load out_* registers; go to OUT.
- OUT:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE.
- in_ready is 1 only in IDLE. No request overlap.
- Latency: request accepted at edge 0 → out_valid high after edge 4. Minimum 5 cycles per update including handshake.
- Multiplier Overflow/Underflow are ORed into err.
- FP compare rule (sign-magnitude):
  - +0 equals -0.
  - Differing signs: the positive operand is greater.
  - Both positive: larger {exp,mant} is greater.
  - Both negative: smaller {exp,mant} is greater.
  - Equal counts as >= (fires).
- The same id may be requested back-to-back. The second request reads the already written-back value.

Decomposition:
- Shared package lif_pkg holds:
  - FSM state encoding.
  - FP32 constants for default DECAY/GAIN/V_REST/V_TH/V_RESET.
  - FP field widths (sign 1, exp 8, mant 23).
- Natural sub-module: fp_compare_ge (combinational a>=b for FP32 per the rule above), reused by later threshold/weight logic.

Test Plan:
- Reset, then request id=0, I=32'h40A00000 (5.0): P1=-61.75, P2=0.5 → out_v=32'hC2750000 (-61.25), out_spike=0, out_valid 4 cycles after accept.
- Request id=3, I=32'h42C80000 (100.0): S=-51.75 ≥ -55 → out_spike=1, out_v=32'hC28C0000. A follow-up id=3 with I=0 yields -66.5 (32'hC2850000), no spike.
- Hold out_ready=0 for 6 cycles after out_valid: out_* stable, in_ready=0, a new in_valid is ignored. Release → single handshake, return to IDLE.
- Two successive id=0 requests with I=5.0: second result = 0.95*(-61.25)+0.5 = -57.6875 (32'hC266C000), confirming writeback.
- Assert RESET low during ADD state: outputs go to reset values immediately. After release, id=0 with I=0 gives -61.75 (potential restored to V_REST).
- I=32'h7F7FFFFF (max float): GAIN product finite, sum finite, spike=1. I=32'h7F800000 (Inf): out_err=1, out_spike=0, out_v=V_RESET.
